ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage sitting directly upstream of the instruction decoder/control unit. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents the fetched 32-bit instruction together with its PC and PC+4 to the decoder and datapath. Accepts branch/jump redirects from the execute stage and injects an all-zero bubble (decodes to all control signals deasserted) whenever no valid instruction is held.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- TIMEOUT_CYC, 16, max cycles waiting for imem_ack before error (0 disables timeout; 8-bit counter, so legal range 0-255)

- clk  input  1  core clock, all state updates on rising edge
- nrst  input  1  reset, asynchronous assert, active-low
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  word address being fetched (bits[1:0] always 0)
- imem_ack  input  1  memory response; imem_rdata valid in same cycle
- imem_rdata  input  32  fetched instruction word
- stall  input  1  downstream not ready; hold current instruction
- redirect  input  1  branch taken / jump; 1-cycle pulse
- redirect_pc  input  32  target PC; bits[1:0] ignored (treated as 0)
- instr  output  32  instruction to decoder; 32'h0000_0000 when instr_valid=0
- instr_pc  output  32  PC of instr
- pc_plus4  output  32  instr_pc + 4 (JAL/JALR link value), mod 2^32
- instr_valid  output  1  instr holds a real fetched instruction
- fetch_err  output  1  sticky fetch timeout flag

## Operation
- States: IDLE, REQ, VALID, DROP, ERR.
- imem_req = 1 in REQ and DROP only; imem_addr = fetch PC register (stable while imem_req=1).
- IDLE: entered on reset; next edge -> REQ.
- REQ: on imem_ack -> latch imem_rdata into instr, fetch PC into instr_pc, -> VALID.
- VALID: instr_valid=1. If stall=0 -> fetch PC += 4, -> REQ. If stall=1 stay, outputs frozen.
- Redirect (priority over stall and ack):
  - in VALID or IDLE: fetch PC <= {redirect_pc[31:2],2'b00}, instr cleared to bubble, -> REQ.
  - in REQ with imem_ack same cycle: returning data discarded, fetch PC <= target, -> REQ (new request next cycle).
  - in REQ without ack: in-flight request cannot be cancelled; store target, -> DROP.
  - in DROP: on ack discard data, fetch PC <= stored target, -> REQ. A further redirect in DROP overwrites stored target.
- Timeout: counter clears on entry to REQ/DROP and on ack, increments each REQ/DROP cycle without ack; when it reaches TIMEOUT_CYC (nonzero) -> ERR.
- ERR: imem_req=0, instr bubble, instr_valid=0, fetch_err=1; exits only via reset. Redirect ignored.
- PC arithmetic 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset values (asynchronous, while nrst=0): state IDLE, fetch PC = RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=RESET_PC, pc_plus4=RESET_PC+4, instr_valid=0, fetch_err=0, timeout counter 0.
- Cycle 0 = first rising edge with nrst=1: IDLE->REQ; imem_req high from cycle 0 to the ack edge.
- Ack at edge n -> instr/instr_valid updated after edge n (visible during cycle n+1).
- Zero-wait memory (ack in first REQ cycle): one instruction per 2 cycles.
- Redirect sampled at edge n -> request to target visible after edge n (or after the DROP ack edge).
- Reset asserted mid-transaction: immediately returns to reset values; any later ack for the aborted request is ignored in IDLE.
- All outputs registered or decoded from state only; no combinational path from inputs to outputs.

## Test plan
- Reset, RESET_PC=32'h100, zero-wait memory returning 32'h00A00093 -> imem_addr 0x100, 0x104, 0x108 on successive REQ cycles; instr_valid every 2nd cycle; pc_plus4=0x104 with instr_pc=0x100.
- stall held 3 cycles during VALID at PC 0x104 -> instr, instr_pc unchanged, imem_req=0 throughout; fetch of 0x108 starts the cycle after stall drops.
- Memory with 3-cycle ack latency, redirect to 32'h203 during REQ for 0x108 -> DROP, first ack data discarded (instr_valid stays 0), next request at 0x200, instr_pc=0x200.
- redirect to 0x40 coinciding with ack in REQ -> ack data discarded, next cycle imem_addr=0x40.
- TIMEOUT_CYC=4, ack never returned -> after 4 REQ cycles fetch_err=1, imem_req=0, instr=0; stays until nrst pulse, then restarts at RESET_PC.
- Fetch at 0xFFFF_FFFC with no stall -> pc_plus4=0x0, next imem_addr=0x0.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack sequencing, branch redirect
// handling with in-flight drop, and a sticky timeout error.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               nrst,
  ifetch_unit_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        pc_plus4,
  output logic               instr_valid,
  output logic               fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, VALID, DROP, ERR} state_t;

  localparam bit         TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] tgt_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] pc_plus4_q;
  logic [7:0]  tmo_q;

  logic [31:0] redir_tgt_d;
  logic        tmo_hit_d;

  assign redir_tgt_d = {redirect_pc[31:2], 2'b00};
  assign tmo_hit_d   = TMO_EN && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      tgt_q      <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      tmo_q      <= 8'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) fetch_pc_q <= redir_tgt_d;
          tmo_q   <= 8'h0;
          state_q <= REQ;
        end
        REQ: begin
          if (imem.imem_ack) begin
            tmo_q <= 8'h0;
            if (redirect) begin
              fetch_pc_q <= redir_tgt_d;
              state_q    <= REQ;
            end else begin
              instr_q    <= imem.imem_rdata;
              instr_pc_q <= fetch_pc_q;
              pc_plus4_q <= fetch_pc_q + 32'd4;
              state_q    <= VALID;
            end
          end else if (redirect) begin
            // The outstanding request cannot be withdrawn; park the target
            // until its ack arrives.
            tgt_q   <= redir_tgt_d;
            tmo_q   <= 8'h0;
            state_q <= DROP;
          end else if (tmo_hit_d) begin
            instr_q <= 32'h0;
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        VALID: begin
          if (redirect) begin
            fetch_pc_q <= redir_tgt_d;
            instr_q    <= 32'h0;
            tmo_q      <= 8'h0;
            state_q    <= REQ;
          end else if (!stall) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            tmo_q      <= 8'h0;
            state_q    <= REQ;
          end
        end
        DROP: begin
          if (imem.imem_ack) begin
            fetch_pc_q <= redirect ? redir_tgt_d : tgt_q;
            tmo_q      <= 8'h0;
            state_q    <= REQ;
          end else begin
            if (redirect) tgt_q <= redir_tgt_d;
            if (tmo_hit_d) begin
              instr_q <= 32'h0;
              state_q <= ERR;
            end else begin
              tmo_q <= tmo_q + 8'd1;
            end
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign imem.imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr = fetch_pc_q;
  assign instr_valid    = (state_q == VALID);
  assign fetch_err      = (state_q == ERR);
  assign instr          = instr_valid ? instr_q : 32'h0;
  assign instr_pc       = instr_pc_q;
  assign pc_plus4       = pc_plus4_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural imem with variable latency,
// scoreboard of delivered instructions, and directed redirect/stall/timeout checks.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, instr_pc, pc_plus4;
  logic        instr_valid, fetch_err;

  ifetch_unit_if imem_if ();

  ifetch_unit #(
    .RESET_PC   (32'h0000_0100),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .imem       (imem_if.master),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_plus4   (pc_plus4),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model and scoreboard producer
  int          lat        = 1;
  bit          mem_en     = 1'b1;
  bit          const_mode = 1'b1;
  int          wait_cnt   = 0;
  bit          drop_pend  = 1'b0;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return const_mode ? 32'h00A0_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  initial begin
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        wait_cnt = 0;
        drop_pend = 1'b0;
        imem_if.imem_ack = 1'b0;
        sb_q.delete();
      end else begin
        if (imem_if.imem_ack) wait_cnt = 0;
        imem_if.imem_ack = 1'b0;
        if (mem_en && imem_if.imem_req) begin
          if (wait_cnt >= lat - 1) begin
            imem_if.imem_ack   = 1'b1;
            imem_if.imem_rdata = mem_word(imem_if.imem_addr);
            if (redirect || drop_pend) drop_pend = 1'b0;
            else sb_q.push_back({imem_if.imem_addr, mem_word(imem_if.imem_addr)});
          end else begin
            wait_cnt++;
            if (redirect) drop_pend = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard consumer: each new instruction pops one expected entry
  bit prev_v = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (instr_valid && !prev_v) begin
          if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
          end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            chk("sb_pc", instr_pc, e[63:32]);
            chk("sb_instr", instr, e[31:0]);
            chk("sb_plus4", pc_plus4, e[63:32] + 32'd4);
          end
        end
        if (!instr_valid) chk("bubble", instr, 32'h0);
        prev_v = instr_valid;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (instr_valid) return;
      tick();
    end
    chk(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rst_addr", imem_if.imem_addr, 32'h100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h100);
    chk("rst_plus4", pc_plus4, 32'h104);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);

    // Zero-wait streaming
    @(negedge clk); nrst = 1'b1;
    tick();
    chk("zw_req0", {31'd0, imem_if.imem_req}, 32'd1);
    chk("zw_addr0", imem_if.imem_addr, 32'h100);
    tick();
    chk("zw_valid0", {31'd0, instr_valid}, 32'd1);
    chk("zw_instr0", instr, 32'h00A0_0093);
    chk("zw_ipc0", instr_pc, 32'h100);
    chk("zw_plus4", pc_plus4, 32'h104);
    chk("zw_noreq", {31'd0, imem_if.imem_req}, 32'd0);
    tick();
    chk("zw_addr1", imem_if.imem_addr, 32'h104);
    chk("zw_valid1", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("zw_ipc1", instr_pc, 32'h104);

    // Stall holds the current instruction
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_valid", {31'd0, instr_valid}, 32'd1);
      chk("st_ipc", instr_pc, 32'h104);
      chk("st_instr", instr, 32'h00A0_0093);
      chk("st_req", {31'd0, imem_if.imem_req}, 32'd0);
    end
    stall = 1'b0; const_mode = 1'b0; lat = 3;
    tick();
    chk("st_addr", imem_if.imem_addr, 32'h108);
    chk("st_req1", {31'd0, imem_if.imem_req}, 32'd1);

    // Redirect while a slow request is outstanding -> DROP
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    chk("dr_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("dr_addr", imem_if.imem_addr, 32'h108);
    tick();
    chk("dr_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("dr_valid2", {31'd0, instr_valid}, 32'd0);
    chk("dr_newaddr", imem_if.imem_addr, 32'h200);
    chk("dr_newreq", {31'd0, imem_if.imem_req}, 32'd1);
    wait_valid("dr_wait");
    chk("dr_ipc", instr_pc, 32'h200);

    // Redirect coinciding with ack
    lat = 1;
    tick();
    chk("ra_addr0", imem_if.imem_addr, 32'h204);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("ra_valid", {31'd0, instr_valid}, 32'd0);
    chk("ra_addr", imem_if.imem_addr, 32'h40);
    chk("ra_req", {31'd0, imem_if.imem_req}, 32'd1);
    tick();
    chk("ra_ipc", instr_pc, 32'h40);

    // Wrap at the top of the address space (low bits of target ignored)
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("wr_addr", imem_if.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_plus4", pc_plus4, 32'h0);
    tick();
    chk("wr_next", imem_if.imem_addr, 32'h0);
    tick();
    chk("wr_ipc0", instr_pc, 32'h0);

    // Timeout: memory never answers
    mem_en = 1'b0;
    tick();
    chk("to_req0", {31'd0, imem_if.imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_req", {31'd0, imem_if.imem_req}, 32'd1);
      chk("to_noerr", {31'd0, fetch_err}, 32'd0);
    end
    tick();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_reqoff", {31'd0, imem_if.imem_req}, 32'd0);
    chk("to_instr", instr, 32'h0);
    chk("to_valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    chk("to_sticky", {31'd0, fetch_err}, 32'd1);
    chk("to_sticky_req", {31'd0, imem_if.imem_req}, 32'd0);

    // Asynchronous reset clears the error and restarts at RESET_PC
    nrst = 1'b0;
    #1;
    chk("ar_err", {31'd0, fetch_err}, 32'd0);
    chk("ar_addr", imem_if.imem_addr, 32'h100);
    tick();
    mem_en = 1'b1;
    @(negedge clk); nrst = 1'b1;
    tick();
    chk("ar_req", {31'd0, imem_if.imem_req}, 32'd1);
    chk("ar_addr1", imem_if.imem_addr, 32'h100);
    tick();
    chk("ar_ipc", instr_pc, 32'h100);

    // Reset in the middle of a slow request
    lat = 3;
    tick();
    chk("mr_addr", imem_if.imem_addr, 32'h104);
    tick();
    nrst = 1'b0;
    #1;
    chk("mr_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("mr_faddr", imem_if.imem_addr, 32'h100);
    chk("mr_ipc", instr_pc, 32'h100);
    tick();
    @(negedge clk); nrst = 1'b1;
    tick();
    chk("mr_addr2", imem_if.imem_addr, 32'h100);
    wait_valid("mr_wait");
    stall = 1'b1;
    chk("mr_ipc2", instr_pc, 32'h100);
    @(negedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
